// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and shared-bus signals of the OAM DMA controller.
// The master side is the CPU/bus environment, and the slave side is the controller.
interface oam_dma_ctrl_if #(
    parameter int ADDR_N = 16,
    parameter int DATA_N = 8
);
    logic [ADDR_N-1:0] cpu_addr;
    logic [DATA_N-1:0] cpu_wdata;
    logic              cpu_we;
    logic              rdy;
    logic              busy;
    logic [ADDR_N-1:0] bus_addr;
    logic [DATA_N-1:0] bus_wdata;
    logic              bus_we;
    logic [DATA_N-1:0] bus_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, bus_rdata,
        input  rdy, busy, bus_addr, bus_wdata, bus_we
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, bus_rdata,
        output rdy, busy, bus_addr, bus_wdata, bus_we
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG halts the CPU and copies the
// 256-byte page {page,00..FF} to OAM_PORT as alternating read/write bus cycles.
// Reads always land on get (parity 0) cycles, so an ALIGN cycle is inserted
// when the halt would otherwise release onto a put cycle.
module oam_dma_ctrl #(
    parameter int                ADDR_N   = 16,
    parameter int                DATA_N   = 8,
    parameter logic [ADDR_N-1:0] DMA_REG  = 16'h4014,
    parameter logic [ADDR_N-1:0] OAM_PORT = 16'h2004
) (
    input logic           clk,
    input logic           n_reset,
    oam_dma_ctrl_if.slave io
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic              parity_reg;
    logic [DATA_N-1:0] page_reg, page_next;
    logic [7:0]        idx_reg, idx_next;
    logic [DATA_N-1:0] data_buf_reg, data_buf_next;

    logic [ADDR_N-1:0] dma_addr;
    logic [ADDR_N-1:0] bus_addr_c;
    logic [DATA_N-1:0] bus_wdata_c;
    logic              bus_we_c;
    logic              rdy_c;
    logic              busy_c;

    // Source address of the current DMA byte; idx never carries into page.
    assign dma_addr = ADDR_N'({page_reg, idx_reg});

    // State, parity and datapath registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg    <= IDLE;
            parity_reg   <= 1'b0;
            page_reg     <= '0;
            idx_reg      <= '0;
            data_buf_reg <= '0;
        end else begin
            state_reg    <= state_next;
            parity_reg   <= ~parity_reg;
            page_reg     <= page_next;
            idx_reg      <= idx_next;
            data_buf_reg <= data_buf_next;
        end
    end

    // Next-state logic and bus multiplexing between the CPU and the DMA engine.
    always_comb begin
        state_next    = state_reg;
        page_next     = page_reg;
        idx_next      = idx_reg;
        data_buf_next = data_buf_reg;
        rdy_c         = 1'b0;
        busy_c        = 1'b1;
        bus_addr_c    = dma_addr;
        bus_wdata_c   = io.cpu_wdata;
        bus_we_c      = 1'b0;

        case (state_reg)
            IDLE: begin
                rdy_c      = 1'b1;
                busy_c     = 1'b0;
                bus_addr_c = io.cpu_addr;
                bus_we_c   = io.cpu_we;
                if (io.cpu_we && io.cpu_addr == DMA_REG) begin
                    page_next  = io.cpu_wdata;
                    idx_next   = 8'h00;
                    state_next = HALT;
                end
            end
            HALT: begin
                // A CPU write cannot be stalled, so it goes out on the bus and
                // the halt is extended; DMA_REG writes here leave page alone.
                bus_addr_c = io.cpu_addr;
                bus_we_c   = io.cpu_we;
                if (!io.cpu_we) begin
                    // Next cycle is a get cycle when the current parity is 1.
                    state_next = parity_reg ? READ : ALIGN;
                end
            end
            ALIGN: begin
                // Dummy read to burn the put cycle.
                state_next = READ;
            end
            READ: begin
                data_buf_next = io.bus_rdata;
                state_next    = WRITE;
            end
            WRITE: begin
                bus_addr_c  = OAM_PORT;
                bus_wdata_c = data_buf_reg;
                bus_we_c    = 1'b1;
                idx_next    = idx_reg + 8'd1;
                state_next  = (idx_reg == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign io.rdy       = rdy_c;
    assign io.busy      = busy_c;
    assign io.bus_addr  = bus_addr_c;
    assign io.bus_wdata = bus_wdata_c;
    assign io.bus_we    = bus_we_c;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: triggers DMAs on both parities, with
// halt-extending CPU writes, at the top page, and with a mid-transfer reset.
module tb_oam_dma_ctrl;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    oam_dma_ctrl_if #(.ADDR_N(16), .DATA_N(8)) dif ();

    oam_dma_ctrl #(
        .ADDR_N  (16),
        .DATA_N  (8),
        .DMA_REG (16'h4014),
        .OAM_PORT(16'h2004)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .io     (dif)
    );

    // Memory content seen on the shared bus: a simple function of the address.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign dif.bus_rdata = mem_byte(dif.bus_addr);

    // Reference get/put parity: 0 in the first cycle after reset.
    logic tb_par;
    always @(posedge clk) tb_par <= n_reset ? ~tb_par : 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        dif.cpu_we    = 1'b0;
        dif.cpu_addr  = 16'h8123;
        dif.cpu_wdata = 8'h3C;
        @(negedge clk);
    endtask

    // Entered mid-cycle (after a negedge) in an IDLE cycle. Triggers a DMA of
    // page pg, issues n_wr CPU writes to DMA_REG during the halt, and checks
    // every stalled cycle. abort_byte >= 0 resets the DUT at that byte's read.
    task automatic dma_run(input logic [7:0] pg, input int n_wr,
                           input int exp_stall, input int abort_byte);
        bit          align;
        bit          done;
        bit          aborted;
        int          stall;
        int          seq_err;
        int          writes;
        int          base;
        int          j;
        int          k;
        int          err;
        int          wr;
        bit          exp_we;
        bit          chk_wd;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd;
        logic [15:0] last_rd;
        logic [7:0]  b;

        align   = (exp_stall - n_wr - 513) == 1;
        base    = n_wr + 1 + (align ? 1 : 0);
        done    = 0;
        aborted = 0;
        stall   = 0;
        seq_err = 0;
        writes  = 0;
        last_rd = 16'h0000;

        dif.cpu_addr  = 16'h4014;
        dif.cpu_wdata = pg;
        dif.cpu_we    = 1'b1;
        #1;
        check("trig_pass", {15'd0, dif.bus_we, dif.bus_addr}, {15'd0, 1'b1, 16'h4014});

        for (int c = 0; c < 1200; c++) begin
            @(posedge clk); #1;
            dif.cpu_we    = (c < n_wr);
            dif.cpu_addr  = (c < n_wr) ? 16'h4014 : 16'h8123;
            dif.cpu_wdata = (c < n_wr) ? 8'h05 : 8'h3C;
            @(negedge clk);
            if (dif.rdy === 1'b1) begin
                done = 1;
                break;
            end
            stall++;
            chk_wd   = 0;
            exp_wd   = 8'h00;
            j        = -1;
            if (c < n_wr) begin
                exp_we = 1; exp_addr = 16'h4014; exp_wd = 8'h05; chk_wd = 1;
            end else if (c == n_wr) begin
                exp_we = 0; exp_addr = 16'h8123;
            end else if (align && c == n_wr + 1) begin
                exp_we = 0; exp_addr = {pg, 8'h00};
            end else begin
                j = c - base;
                b = 8'(j / 2);
                if (j >= 512) seq_err++;
                if (j % 2 == 0) begin
                    exp_we = 0; exp_addr = {pg, b};
                    last_rd = dif.bus_addr;
                end else begin
                    exp_we = 1; exp_addr = 16'h2004; exp_wd = mem_byte({pg, b}); chk_wd = 1;
                end
            end
            if (dif.bus_we === 1'b1 && dif.bus_addr === 16'h2004) writes++;
            if (dif.bus_we !== exp_we || dif.bus_addr !== exp_addr ||
                (chk_wd && dif.bus_wdata !== exp_wd) || $isunknown(dif.bus_wdata) ||
                dif.rdy !== 1'b0 || dif.busy !== 1'b1) begin
                if (seq_err < 3)
                    $display("  cycle %0d: bus_we=%b addr=%h wdata=%h want we=%b addr=%h",
                             c, dif.bus_we, dif.bus_addr, dif.bus_wdata, exp_we, exp_addr);
                seq_err++;
            end
            if (abort_byte >= 0 && j == 2 * abort_byte) begin
                aborted = 1;
                break;
            end
        end

        if (abort_byte >= 0) begin
            check("abort_reached", {31'd0, aborted}, 32'd1);
            check("abort_seq", seq_err, 0);
            @(posedge clk); #1;
            n_reset    = 1'b0;
            dif.cpu_we = 1'b0;
            @(posedge clk); #1;
            n_reset = 1'b1;
            @(negedge clk);
            check("rst_rdy", {31'd0, dif.rdy}, 32'd1);
            check("rst_busy", {31'd0, dif.busy}, 32'd0);
            check("rst_pass", {16'd0, dif.bus_addr}, {16'd0, 16'h8123});
            err = 0;
            wr  = 0;
            for (k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                dif.cpu_addr = 16'h0100 + 16'(k);
                dif.cpu_we   = 1'b0;
                @(negedge clk);
                if (dif.rdy !== 1'b1 || dif.busy !== 1'b0 || dif.bus_we !== 1'b0 ||
                    dif.bus_addr !== dif.cpu_addr) err++;
                if (dif.bus_we === 1'b1 && dif.bus_addr === 16'h2004) wr++;
            end
            check("post_rst_idle", err, 0);
            check("post_rst_oam_wr", wr, 0);
            $display("dma page %02h: reset at byte %0d, %0d writes before reset", pg, abort_byte, writes);
        end else begin
            check("done", {31'd0, done}, 32'd1);
            check("stall", stall, exp_stall);
            check("seq", seq_err, 0);
            check("oam_writes", writes, 256);
            check("last_rd", {16'd0, last_rd}, {16'd0, pg, 8'hFF});
            check("end_busy", {31'd0, dif.busy}, 32'd0);
            $display("dma page %02h: halt writes %0d, stall %0d, oam writes %0d", pg, n_wr, stall, writes);
        end
    endtask

    initial begin
        dif.cpu_addr  = 16'h8123;
        dif.cpu_wdata = 8'h3C;
        dif.cpu_we    = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        @(negedge clk);
        check("reset_rdy", {31'd0, dif.rdy}, 32'd1);
        check("reset_busy", {31'd0, dif.busy}, 32'd0);
        check("reset_addr", {16'd0, dif.bus_addr}, {16'd0, 16'h8123});
        check("reset_wdata", {24'd0, dif.bus_wdata}, {24'd0, 8'h3C});
        check("reset_we", {31'd0, dif.bus_we}, 32'd0);
        dif.cpu_addr = 16'h0300;
        dif.cpu_we   = 1'b1;
        #1;
        check("idle_wr_pass", {15'd0, dif.bus_we, dif.bus_addr}, {15'd0, 1'b1, 16'h0300});
        dif.cpu_we   = 1'b0;
        dif.cpu_addr = 16'h8123;
        #1;
        $display("reset: rdy=%b busy=%b", dif.rdy, dif.busy);

        dma_run(8'h02, 0, 513, -1);   // trigger on a get cycle: no ALIGN
        dma_run(8'h03, 0, 513, -1);   // back-to-back in the first IDLE cycle
        idle_cycle();
        dma_run(8'h04, 0, 514, -1);   // trigger on a put cycle: ALIGN inserted
        dma_run(8'h10, 2, 515, -1);   // two halt writes of 05 to DMA_REG
        dma_run(8'hFF, 0, 513, -1);   // top page, no wrap
        dma_run(8'h07, 0, 513, 100);  // reset at byte 100
        if (tb_par) idle_cycle();
        dma_run(8'h08, 0, 513, -1);   // normal operation after the abort

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
